vram_scan_arbiter: RTL and testbench

VRAM_SCAN_ARBITER -- requirements
Module: vram_scan_arbiter

---
 rtl/vram_scan_arbiter_if.sv | 34 +++
 rtl/vram_scan_arbiter.sv | 122 ++++++++++++
 tb/tb_vram_scan_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_scan_arbiter_if.sv
// Bus bundle for vram_scan_arbiter: CPU port, scan-line control, line-buffer read and VRAM command.
// slave = arbiter side, master = system/CPU/memory side.
interface vram_scan_arbiter_if #(
  parameter int WORDS_PER_LINE = 32
);
  localparam int IW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  logic          cpu_req;
  logic          cpu_we;
  logic [14:0]   cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack;
  logic          line_start;
  logic [7:0]    line_y;
  logic [IW-1:0] buf_rd_addr;
  logic [15:0]   buf_rd_data;
  logic [14:0]   mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          fetch_busy;
  logic          overrun;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, line_start, line_y, buf_rd_addr, mem_rdata,
    output cpu_rdata, cpu_ack, buf_rd_data, mem_addr, mem_we, mem_wdata, fetch_busy, overrun
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, line_start, line_y, buf_rd_addr, mem_rdata,
    input  cpu_rdata, cpu_ack, buf_rd_data, mem_addr, mem_we, mem_wdata, fetch_busy, overrun
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: scan-line prefetch into a double line buffer, CPU accesses in free slots.
// Define VRAM_FAIR_EN to interleave CPU slots with the prefetch (fetch, CPU, fetch, ...).
module vram_scan_arbiter #(
  parameter int VRAM_BASE      = 16384,
  parameter int WORDS_PER_LINE = 32
) (
  input  logic               clk,
  input  logic               reset,
  vram_scan_arbiter_if.slave bus
);
  localparam int IW     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int FW     = $clog2(WORDS_PER_LINE + 1);
  localparam int STAGES = 1;
  localparam logic [FW-1:0] FETCH_END = FW'(WORDS_PER_LINE);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CPU} state_t;

  state_t          state;
  logic [7:0]      line_y_q;
  logic [FW-1:0]   fidx;              // next line index to issue
  logic            front;             // bank shown on buf_rd_data
  logic [STAGES:0] vld_pipe;          // [0] fetch read on bus now, [1] its data on mem_rdata now
  logic [IW-1:0]   cmd_idx, wr_idx;
  logic [15:0]     bank [2][WORDS_PER_LINE];

  logic last_wr, fetch_left, cpu_ok;

  function automatic logic [14:0] fetch_addr(input logic [7:0] y, input logic [FW-1:0] i);
    return 15'(32'(VRAM_BASE) + 32'(y) * 32'(WORDS_PER_LINE) + 32'(i));
  endfunction

  assign last_wr    = vld_pipe[1] && (wr_idx == LAST_IDX);
  assign fetch_left = (fidx != FETCH_END);
  // Holding off in the ack cycle keeps a master that drops req late from getting a second grant.
  assign cpu_ok     = bus.cpu_req && !bus.cpu_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      line_y_q       <= '0;
      fidx           <= '0;
      front          <= 1'b0;
      vld_pipe       <= '0;
      cmd_idx        <= '0;
      wr_idx         <= '0;
      bus.cpu_ack    <= 1'b0;
      bus.mem_addr   <= 15'(VRAM_BASE);
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.fetch_busy <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.cpu_ack <= (state == CPU);
      bus.mem_we  <= 1'b0;
      vld_pipe    <= {vld_pipe[0], 1'b0};
      wr_idx      <= cmd_idx;
      if (last_wr) bus.fetch_busy <= 1'b0;

      if (bus.line_start) begin
        // A line_start landing on the final data write still delivers a complete line.
        if (bus.fetch_busy && !last_wr) bus.overrun <= 1'b1;
        front          <= ~front;
        line_y_q       <= bus.line_y;
        bus.mem_addr   <= fetch_addr(bus.line_y, '0);
        cmd_idx        <= '0;
        fidx           <= FW'(1);
        vld_pipe       <= {1'b0, 1'b1};  // drop the abandoned line's in-flight read
        bus.fetch_busy <= 1'b1;
        state          <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            if (cpu_ok) begin
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_wdata <= bus.cpu_wdata;
              state         <= CPU;
            end
          end
          FETCH: begin
            if (!fetch_left) state <= IDLE;
`ifdef VRAM_FAIR_EN
            else if (cpu_ok) begin
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_wdata <= bus.cpu_wdata;
              state         <= CPU;
            end
`endif
            else begin
              bus.mem_addr <= fetch_addr(line_y_q, fidx);
              cmd_idx      <= fidx[IW-1:0];
              fidx         <= fidx + 1'b1;
              vld_pipe     <= {vld_pipe[0], 1'b1};
            end
          end
          CPU: begin
            if (bus.fetch_busy && fetch_left) begin
              bus.mem_addr <= fetch_addr(line_y_q, fidx);
              cmd_idx      <= fidx[IW-1:0];
              fidx         <= fidx + 1'b1;
              vld_pipe     <= {vld_pipe[0], 1'b1};
              state        <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Fill side always targets the bank not on display; the swap and the write share an edge safely.
  always_ff @(posedge clk) begin
    if (vld_pipe[1]) bank[~front][wr_idx] <= bus.mem_rdata;
  end

  assign bus.buf_rd_data = bank[front][bus.buf_rd_addr];
  assign bus.cpu_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: CPU vector table, scan-line corner sequences and a randomized mix
// checked against a shadow-memory model of VRAM and of the line each swap should display.
module tb_vram_scan_arbiter;
  localparam int VB  = 16384;
  localparam int WPL = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #50 clk = ~clk;

  vram_scan_arbiter_if #(.WORDS_PER_LINE(WPL)) bus ();
  vram_scan_arbiter #(.VRAM_BASE(VB), .WORDS_PER_LINE(WPL)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Screen word k (at VB+k) powers up holding k; everything wraps to 16 bits.
  function automatic logic [15:0] init_val(input int a);
    return 16'(a - VB);
  endfunction

  // VRAM device: read data one cycle after the address.
  logic [15:0] vram    [32768];
  bit          vram_wr [32768];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      vram[int'(bus.mem_addr)]    <= bus.mem_wdata;
      vram_wr[int'(bus.mem_addr)] <= 1'b1;
    end
    bus.mem_rdata <= vram_wr[int'(bus.mem_addr)] ? vram[int'(bus.mem_addr)] : init_val(int'(bus.mem_addr));
  end

  // Reference model: what every VRAM word should hold after completed CPU writes.
  logic [15:0] shadow [int];
  function automatic logic [15:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [7:0] y);
    bus.line_start = 1'b1;
    bus.line_y     = y;
    tick();
    bus.line_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && bus.fetch_busy; i++) tick();
    chk("fetch_done_bound", 32'(bus.fetch_busy), 32'd0);
  endtask

  // Whole front bank against the model's idea of line y.
  task automatic check_front(input logic [7:0] y, input string nm);
    int bad = 0;
    for (int i = 0; i < WPL; i++) begin
      bus.buf_rd_addr = 5'(i);
      #1;
      if (bus.buf_rd_data !== shadow_rd(VB + int'(y) * WPL + i)) bad++;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  task automatic cpu_op(input logic we, input logic [14:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int we_cnt, output int cmd_ok);
    rd = '0; lat = 0; we_cnt = 0; cmd_ok = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (bus.mem_we) begin
        we_cnt++;
        if (bus.mem_addr == a && bus.mem_wdata == d) cmd_ok = 1;
      end
      if (bus.cpu_ack) begin
        lat = c;
        rd  = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    if (we && lat != 0) shadow[int'(a)] = d;
  endtask

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [15:0] rd;
    int lat, wec, cok, prev_y;
    int busy, bad_addr, we_seen, ack_c, done_c, we_c, we_busy, ack_seen;

    vecs[0] = '{1'b1, 15'd16384, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 15'd16384, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 15'd100,   16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 15'd100,   16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 15'd7,     16'h0000, 16'hC007};
    vecs[5] = '{1'b1, 15'd32767, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b0, 15'd32767, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b0, 15'd16389, 16'h0000, 16'h0005};

    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.line_start = 1'b0; bus.line_y = '0; bus.buf_rd_addr = '0;
    repeat (3) tick();
    chk("rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'(VB));
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_fetch_busy", 32'(bus.fetch_busy), 32'd0);
    chk("rst_overrun",    32'(bus.overrun),    32'd0);
    rst_n = 1'b1;
    tick();

    // CPU accesses from IDLE: command next cycle, ack the cycle after.
    for (int i = 0; i < 8; i++) begin
      cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wec, cok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_we_cycles", i), 32'(wec), 32'(vecs[i].we));
      if (vecs[i].we) chk($sformatf("vec%0d_wr_cmd", i), 32'(cok), 32'd1);
      else            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      tick();
      chk($sformatf("vec%0d_ack_pulse", i), 32'(bus.cpu_ack), 32'd0);
    end

    // Line 3: consecutive addresses, 33 busy cycles, then displayed after the next swap.
    start_line(8'd3);
    busy = 0; bad_addr = 0; we_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= WPL && bus.mem_addr !== 15'(VB + 3 * WPL + c - 1)) bad_addr++;
      if (bus.mem_we) we_seen++;
      if (bus.fetch_busy) busy++;
      tick();
    end
    chk("l3_addr_errs",  32'(bad_addr), 32'd0);
    chk("l3_busy_len",   32'(busy),     32'd33);
    chk("l3_no_we",      32'(we_seen),  32'd0);
    start_line(8'd0);
    bus.buf_rd_addr = 5'd5;
    #1 chk("l3_buf5", 32'(bus.buf_rd_data), 32'd101);
    check_front(8'd3, "l3_front");
    repeat (10) tick();
    bus.buf_rd_addr = 5'd5;
    #1 chk("l3_buf5_midfetch", 32'(bus.buf_rd_data), 32'd101);
    wait_idle();

    // CPU request two cycles into a fetch.
    bus.line_start = 1'b1; bus.line_y = 8'd1;
    tick();
    bus.line_start = 1'b0;
    check_front(8'd0, "l0_front");
    ack_c = 0; done_c = 0; we_c = 0; we_busy = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 2) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'd200; bus.cpu_wdata = 16'h5A5A;
      end
      if (bus.mem_we) begin
        if (we_c == 0) we_c = c;
        if (bus.fetch_busy) we_busy++;
      end
      if (bus.cpu_ack && ack_c == 0) begin
        ack_c = c;
        bus.cpu_req = 1'b0;
      end
      if (!bus.fetch_busy && done_c == 0) done_c = c;
      tick();
    end
    if (ack_c != 0) shadow[200] = 16'h5A5A;
`ifdef VRAM_FAIR_EN
    chk("fair_cpu_slot", 32'(we_c), 32'd3);
    chk("fair_ack_by_5", 32'(ack_c >= 3 && ack_c <= 5), 32'd1);
    chk("fair_done_65",  32'(done_c > 0 && done_c <= 65), 32'd1);
`else
    chk("strict_ack_cycle",   32'(ack_c),   32'd35);
    chk("strict_we_in_fetch", 32'(we_busy), 32'd0);
    chk("strict_done_cycle",  32'(done_c),  32'd34);
`endif

    // line_start while a CPU read is on the bus.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd50;
    tick();
    chk("lscpu_cmd_addr", 32'(bus.mem_addr), 32'd50);
    bus.line_start = 1'b1; bus.line_y = 8'd2;
    tick();
    bus.line_start = 1'b0;
    chk("lscpu_ack",        32'(bus.cpu_ack),    32'd1);
    chk("lscpu_rdata",      32'(bus.cpu_rdata),  32'(shadow_rd(50)));
    bus.cpu_req = 1'b0;
    chk("lscpu_fetch_addr", 32'(bus.mem_addr),   32'(VB + 2 * WPL));
    chk("lscpu_busy",       32'(bus.fetch_busy), 32'd1);
    check_front(8'd1, "l1_front");
    wait_idle();
    chk("overrun_clear", 32'(bus.overrun), 32'd0);

    // Randomized mix; writes stay below the screen so displayed lines track the model.
    prev_y = 2;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] y;
        wait_idle();
        y = 8'($urandom_range(0, 255));
        start_line(y);
        check_front(8'(prev_y), "rand_front");
        prev_y = int'(y);
      end else begin
        logic        we;
        logic [14:0] a;
        logic [15:0] d;
        we = 1'($urandom_range(0, 1));
        a  = we ? 15'($urandom_range(0, 16383)) : 15'($urandom_range(0, 32767));
        d  = 16'($urandom);
        cpu_op(we, a, d, rd, lat, wec, cok);
        chk("rand_latency_ok", 32'(lat >= 2 && lat <= WPL + 4), 32'd1);
        chk("rand_we_cycles",  32'(wec), 32'(we));
        if (!we) chk("rand_rdata", 32'(rd), 32'(shadow_rd(int'(a))));
      end
    end
    wait_idle();
    chk("rand_no_overrun", 32'(bus.overrun), 32'd0);

    // Missed deadline: second line_start 10 cycles into a fetch.
    start_line(8'd4);
    repeat (9) tick();
    start_line(8'd9);
    chk("ovr_set",        32'(bus.overrun),    32'd1);
    chk("ovr_new_base",   32'(bus.mem_addr),   32'(VB + 9 * WPL));
    chk("ovr_busy",       32'(bus.fetch_busy), 32'd1);
    wait_idle();
    chk("ovr_sticky",     32'(bus.overrun),    32'd1);
    start_line(8'd0);
    check_front(8'd9, "ovr_l9_front");
    wait_idle();
    chk("ovr_sticky2",    32'(bus.overrun),    32'd1);

    // Reset in the middle of a fetch with a CPU read pending.
    start_line(8'd5);
    repeat (4) tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd30;
    #20 rst_n = 1'b0;
    #1;
    chk("mid_rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
    chk("mid_rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("mid_rst_mem_addr",   32'(bus.mem_addr),   32'(VB));
    chk("mid_rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("mid_rst_fetch_busy", 32'(bus.fetch_busy), 32'd0);
    chk("mid_rst_overrun",    32'(bus.overrun),    32'd0);
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.cpu_ack) ack_seen++;
    end
    chk("post_rst_no_ack",   32'(ack_seen),       32'd0);
    chk("post_rst_idle",     32'(bus.fetch_busy), 32'd0);
    chk("post_rst_mem_addr", 32'(bus.mem_addr),   32'(VB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
